// File: rtl/dsp_mode_pkg.sv
// rtl/dsp_mode_pkg.sv - shared mode-word field map and transmitter state encoding
// Purpose: constants describing the 56-bit DSP mode register, the mode-word
//          transmitter state enum and a small sizing helper.
// Ports:   none (package).
package dsp_mode_pkg;

  localparam int MODE_W         = 56;
  localparam int MODE_RESET_BIT = 55;
  localparam int MODE_CHAN_BIT  = 54;
  localparam int MODE_LEVEL_LSB = 0;
  localparam int MODE_LEVEL_MSB = 31;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    GAP,
    LOAD,
    TAIL
  } tx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mode_tx_timer.sv
// rtl/mode_tx_timer.sv - loadable down-counter timing each transmitter phase
// Purpose: holds a phase length; expire_o is high while the count sits at 0.
//          The count stops at 0 rather than wrapping.
// Ports:   clk        system clock
//          reset_n    synchronous active-low reset (count cleared)
//          load_i     reload the count with load_val_i this cycle
//          load_val_i phase length minus one
//          expire_o   count is zero
module mode_tx_timer
  import dsp_mode_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/mode_word_tx.sv
// rtl/mode_word_tx.sv - 3-wire mode-word transmitter (ser_clk, ser_data, ser_load)
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake, shifts it out
//          LSB first with DIV-cycle clock halves, then strobes ser_load for
//          LOAD_CYC cycles so the receiver copies its chain into the mode register.
// Ports:   clk, reset_n          system clock, synchronous active-low reset
//          tx_data, tx_valid     word and request (sampled only on accept)
//          tx_ready              high only while idle
//          done                  one-cycle pulse as the frame completes
//          ser_clk, ser_data     serial clock and data (receiver samples on rise)
//          ser_load              level load strobe
module mode_word_tx
  import dsp_mode_pkg::*;
#(
  parameter int WIDTH    = MODE_W,
  parameter int DIV      = 4,
  parameter int LOAD_CYC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             done,
  output logic             ser_clk,
  output logic             ser_data,
  output logic             ser_load
);

  localparam int CNT_RAW = $clog2(max_int(DIV, LOAD_CYC));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int BIT_W   = $clog2(WIDTH) + 1;

  // Timer counts down to zero inclusive, so a phase of N cycles reloads N-1.
  localparam logic [CNT_W-1:0] DIV_RELOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_RELOAD = CNT_W'(LOAD_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             tx_ready_q, done_q, ser_clk_q, ser_load_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             expire;

  mode_tx_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (expire)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ser_data_d = ser_data_q;
    tmr_load   = 1'b0;
    tmr_val    = DIV_RELOAD;
    shift_nxt  = shift_q >> 1;

    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d    = SETUP;
          shift_d    = tx_data;
          bit_cnt_d  = LAST_BIT;
          ser_data_d = tx_data[0];
          tmr_load   = 1'b1;
        end
      end
      SETUP: begin
        if (expire) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
        end
      end
      HIGH: begin
        if (expire) begin
          tmr_load = 1'b1;
          if (bit_cnt_q == '0) begin
            state_d = GAP;
          end else begin
            // Next bit goes out on the same edge ser_clk falls, never while high.
            state_d    = SETUP;
            shift_d    = shift_nxt;
            ser_data_d = shift_nxt[0];
            bit_cnt_d  = bit_cnt_q - BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (expire) begin
          state_d  = LOAD;
          tmr_load = 1'b1;
          tmr_val  = LOAD_RELOAD;
        end
      end
      LOAD: begin
        if (expire) begin
          state_d  = TAIL;
          tmr_load = 1'b1;
        end
      end
      TAIL: begin
        if (expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so they line up
  // with state_q and never see a combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ser_data_q <= 1'b0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      ser_clk_q  <= 1'b0;
      ser_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ser_data_q <= ser_data_d;
      tx_ready_q <= (state_d == IDLE);
      done_q     <= (state_q == TAIL) && (state_d == IDLE);
      ser_clk_q  <= (state_d == HIGH);
      ser_load_q <= (state_d == LOAD);
    end
  end

  assign tx_ready = tx_ready_q;
  assign done     = done_q;
  assign ser_clk  = ser_clk_q;
  assign ser_data = ser_data_q;
  assign ser_load = ser_load_q;

endmodule

// File: tb/tb_mode_word_tx.sv
// tb/tb_mode_word_tx.sv - bench for mode_word_tx with a serial receiver model
module tb_mode_word_tx;

  localparam int W    = 56;
  localparam int DIV0 = 4;
  localparam int LC0  = 8;
  localparam int DIV1 = 1;
  localparam int LC1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n    [2];
  logic [W-1:0] tx_data  [2];
  logic         tx_valid [2];
  logic         tx_ready [2];
  logic         done     [2];
  logic         ser_clk  [2];
  logic         ser_data [2];
  logic         ser_load [2];

  mode_word_tx #(.WIDTH(W), .DIV(DIV0), .LOAD_CYC(LC0)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .done(done[0]), .ser_clk(ser_clk[0]),
    .ser_data(ser_data[0]), .ser_load(ser_load[0])
  );

  mode_word_tx #(.WIDTH(W), .DIV(DIV1), .LOAD_CYC(LC1)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .done(done[1]), .ser_clk(ser_clk[1]),
    .ser_data(ser_data[1]), .ser_load(ser_load[1])
  );

  int           n_pass = 0;
  int           n_total = 0;
  logic         busy      [2];
  logic         prev_clk  [2];
  logic         prev_load [2];
  logic         prev_data [2];
  logic         prev_done [2];
  logic [W-1:0] chain     [2];
  logic [W-1:0] latch     [2];
  logic [W-1:0] exp_word  [2];
  int           rises     [2];
  int           lowcnt    [2];
  int           loadcnt   [2];
  int           frames    [2];

  function automatic int busy_exp(input int k);
    return (k == 0) ? (2 * DIV0 * W + DIV0 + LC0 + DIV0) : (2 * DIV1 * W + DIV1 + LC1 + DIV1);
  endfunction

  function automatic int lc_exp(input int k);
    return (k == 0) ? LC0 : LC1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: note what the coming edge accepts, step past it, then run the
  // receiver model and protocol checks on the settled outputs.
  task automatic tick();
    logic         acc [2];
    logic         rs  [2];
    logic [W-1:0] cap [2];
    for (int k = 0; k < 2; k++) begin
      acc[k] = tx_valid[k] && tx_ready[k] && rst_n[k];
      rs[k]  = !rst_n[k];
      cap[k] = tx_data[k];
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs[k]) begin
        busy[k] = 1'b0;
      end else if (acc[k]) begin
        busy[k] = 1'b1; exp_word[k] = cap[k];
        rises[k] = 0; lowcnt[k] = 0; loadcnt[k] = 0;
      end
      if (ser_clk[k] && !prev_clk[k]) begin
        chain[k] = {ser_data[k], chain[k][W-1:1]};
        rises[k]++;
      end
      if (ser_load[k]) begin
        latch[k] = chain[k];
        loadcnt[k]++;
      end
      chk($sformatf("d%0d_load_and_clk", k), 64'(ser_load[k] & ser_clk[k]), 64'(0));
      chk($sformatf("d%0d_done_width", k), 64'(done[k] & prev_done[k]), 64'(0));
      chk($sformatf("d%0d_data_stable", k),
          64'((ser_data[k] != prev_data[k]) && (ser_clk[k] || ser_load[k])), 64'(0));
      if (busy[k]) begin
        if (done[k]) begin
          chk($sformatf("d%0d_latch", k), 64'(latch[k]), 64'(exp_word[k]));
          chk($sformatf("d%0d_rises", k), 64'(rises[k]), 64'(W));
          chk($sformatf("d%0d_busy_cycles", k), 64'(lowcnt[k]), 64'(busy_exp(k)));
          chk($sformatf("d%0d_load_cycles", k), 64'(loadcnt[k]), 64'(lc_exp(k)));
          chk($sformatf("d%0d_ready_at_done", k), 64'(tx_ready[k]), 64'(1));
          busy[k] = 1'b0;
          frames[k]++;
        end else begin
          chk($sformatf("d%0d_ready_busy", k), 64'(tx_ready[k]), 64'(0));
          lowcnt[k]++;
        end
      end else begin
        chk($sformatf("d%0d_done_idle", k), 64'(done[k]), 64'(0));
      end
      prev_clk[k]  = ser_clk[k];
      prev_load[k] = ser_load[k];
      prev_data[k] = ser_data[k];
      prev_done[k] = done[k];
    end
  endtask

  task automatic send(input int k, input logic [W-1:0] w);
    tx_data[k]  = w;
    tx_valid[k] = 1'b1;
    for (int i = 0; i < 1000 && !busy[k]; i++) tick();
    chk($sformatf("d%0d_accept_timeout", k), 64'(busy[k]), 64'(1));
    tx_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int start;
    start = frames[k];
    for (int i = 0; i < budget && frames[k] == start; i++) tick();
    chk($sformatf("d%0d_done_timeout", k), 64'(frames[k] != start), 64'(1));
  endtask

  task automatic chk_reset_outputs(input int k);
    chk($sformatf("d%0d_rst_ready", k), 64'(tx_ready[k]), 64'(1));
    chk($sformatf("d%0d_rst_done", k), 64'(done[k]), 64'(0));
    chk($sformatf("d%0d_rst_ser_clk", k), 64'(ser_clk[k]), 64'(0));
    chk($sformatf("d%0d_rst_ser_data", k), 64'(ser_data[k]), 64'(0));
    chk($sformatf("d%0d_rst_ser_load", k), 64'(ser_load[k]), 64'(0));
  endtask

  initial begin
    logic [W-1:0] w;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; tx_valid[k] = 1'b0; tx_data[k] = '0;
      busy[k] = 1'b0; prev_clk[k] = 1'b0; prev_load[k] = 1'b0;
      prev_data[k] = 1'b0; prev_done[k] = 1'b0;
      chain[k] = '0; latch[k] = '0; exp_word[k] = '0;
      rises[k] = 0; lowcnt[k] = 0; loadcnt[k] = 0; frames[k] = 0;
    end
    tick(); tick(); tick();
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    // Single frame with reset and level-LSB bits set.
    send(0, 56'h80_0000_0000_0001);
    wait_done(0, 600);
    chk("t1_latch", 64'(latch[0]), 64'(56'h80_0000_0000_0001));
    chk("t1_reset_bit", 64'(latch[0][55]), 64'(1));

    // Back-to-back frames with tx_valid held high.
    tx_data[0]  = 56'hA5_A5A5_A5A5_A5A5;
    tx_valid[0] = 1'b1;
    for (int i = 0; i < 10 && !busy[0]; i++) tick();
    tx_data[0] = 56'h5A_5A5A_5A5A_5A5A;
    wait_done(0, 600);
    chk("t2_first_latch", 64'(latch[0]), 64'(56'hA5_A5A5_A5A5_A5A5));
    tick();
    chk("t2_single_idle_cycle", 64'(tx_ready[0]), 64'(0));
    tx_valid[0] = 1'b0;
    wait_done(0, 600);
    chk("t2_second_latch", 64'(latch[0]), 64'(56'h5A_5A5A_5A5A_5A5A));

    // Reset in the middle of bit 20 must not disturb the mode register.
    latch[0] = '1;
    send(0, rand_word());
    for (int i = 0; i < 1000 && rises[0] < 20; i++) tick();
    chk("t3_reached_bit20", 64'(rises[0]), 64'(20));
    tick();
    rst_n[0] = 1'b0;
    tick();
    chk_reset_outputs(0);
    chk("t3_no_load", 64'(loadcnt[0]), 64'(0));
    chk("t3_latch_kept", 64'(latch[0]), 64'(56'hFF_FFFF_FFFF_FFFF));
    rst_n[0] = 1'b1;
    tick();
    w = rand_word();
    send(0, w);
    wait_done(0, 600);
    chk("t3_recover_latch", 64'(latch[0]), 64'(w));

    // Fastest timing, randomized words.
    for (int n = 0; n < 6; n++) begin
      w = rand_word();
      send(1, w);
      wait_done(1, 200);
      chk($sformatf("t4_latch_%0d", n), 64'(latch[1]), 64'(w));
    end

    // Input churn while busy is ignored.
    for (int n = 0; n < 2; n++) begin
      w = rand_word();
      send(0, w);
      for (int i = 0; i < 40; i++) begin
        tick();
        tx_data[0]  = rand_word();
        tx_valid[0] = 1'(($urandom() >> 3) & 1);
      end
      tx_valid[0] = 1'b0;
      wait_done(0, 600);
      chk($sformatf("t5_latch_%0d", n), 64'(latch[0]), 64'(w));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
